// File: rtl/l1_cache_pkg.sv
// Shared types and geometry helpers for the parameterised L1 cache.
package l1_cache_pkg;

    localparam int OFFSET_BITS = 5;
    localparam int LINE_BITS   = 256;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        FILL,
        FLUSH_SCAN,
        FLUSH_WB
    } l1_state_t;

    function automatic int idx_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int num_sets);
        return 32 - OFFSET_BITS - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU state for one set: node n lives at tree_q[n-1], 0 = victim on the left.
module plru_tree #(
    parameter int NUM_WAYS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        access_valid,
    input  logic [$clog2(NUM_WAYS)-1:0] access_way,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way
);
    localparam int LVL = $clog2(NUM_WAYS);

    logic [NUM_WAYS-2:0] tree_q, tree_d;
    int vn;
    int un;

    always_comb begin
        vn = 1;
        for (int l = 0; l < LVL; l++)
            vn = 2 * vn + int'(tree_q[vn-1]);
        victim_way = LVL'(vn - NUM_WAYS);
    end

    // Every node on the accessed way's path is turned to point at the other subtree.
    always_comb begin
        tree_d = tree_q;
        un     = 0;
        if (access_valid) begin
            for (int l = 0; l < LVL; l++) begin
                un = (1 << l) + (int'(access_way) >> (LVL - l));
                tree_d[un-1] = ~access_way[LVL-1-l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tree_q <= '0;
        else        tree_q <= tree_d;
    end

endmodule

// File: rtl/param_l1_cache.sv
// N-way set-associative write-back / write-allocate L1 with tree PLRU and whole-cache flush.
module param_l1_cache
    import l1_cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [3:0]           mem_byte_enable,
    input  logic [31:0]          mem_address,
    input  logic [31:0]          mem_wdata,
    output logic [31:0]          mem_rdata,
    output logic                 mem_resp,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_address,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);
    localparam int IB = idx_bits(NUM_SETS);
    localparam int TB = tag_bits(NUM_SETS);
    localparam int WB = $clog2(NUM_WAYS);
    localparam int CW = IB + WB;

    logic [LINE_BITS-1:0] data_q [NUM_WAYS][NUM_SETS];
    logic [TB-1:0]        tag_q  [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS];

    l1_state_t     state_q, state_d;
    logic [WB-1:0] victim_q, victim_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          req, hit, has_inv, flushing;
    logic [IB-1:0] idx, sc_set, wb_set;
    logic [TB-1:0] tag;
    logic [2:0]    word;
    logic [WB-1:0] hit_way, inv_way, sc_way, wb_way;
    logic [WB-1:0] plru_vic [NUM_SETS];
    logic [NUM_WAYS-1:0] hit_vec;
    logic          hit_we, fill_we, plru_acc, clr_dirty;
    logic [LINE_BITS-1:0] hit_line, merged_line, wmask;
    logic          unused_addr_bits;

    assign req              = mem_read | mem_write;
    assign idx              = mem_address[OFFSET_BITS +: IB];
    assign tag              = mem_address[31 -: TB];
    assign word             = mem_address[4:2];
    assign unused_addr_bits = ^mem_address[1:0];

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        inv_way = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            hit_vec[w] = valid_q[idx][w] && (tag_q[w][idx] == tag);
        // Descending walk so the lowest-index match / free way wins.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w])         hit_way = WB'(w);
            if (!valid_q[idx][w])   inv_way = WB'(w);
        end
    end

    assign hit      = |hit_vec;
    assign has_inv  = ~&valid_q[idx];
    assign hit_line = data_q[hit_way][idx];
    assign mem_rdata = hit_line[32*word +: 32];

    always_comb begin
        wmask = '0;
        for (int b = 0; b < LINE_BITS / 8; b++)
            wmask[b*8 +: 8] = {8{(b / 4 == int'(word)) && mem_byte_enable[b % 4]}};
    end
    assign merged_line = (hit_line & ~wmask) | ({8{mem_wdata}} & wmask);

    // Flush walks {set, way} with way in the low bits, so entries go in ascending order.
    assign sc_way     = cnt_q[WB-1:0];
    assign sc_set     = cnt_q[CW-1 -: IB];
    assign flushing   = (state_q == FLUSH_SCAN) || (state_q == FLUSH_WB);
    assign wb_way     = flushing ? sc_way : victim_q;
    assign wb_set     = flushing ? sc_set : idx;
    assign pmem_wdata = data_q[wb_way][wb_set];

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        cnt_d        = cnt_q;
        mem_resp     = 1'b0;
        flush_done   = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        hit_we       = 1'b0;
        fill_we      = 1'b0;
        plru_acc     = 1'b0;
        clr_dirty    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        plru_acc = 1'b1;
                        hit_we   = mem_write;
                    end else begin
                        victim_d = has_inv ? inv_way : plru_vic[idx];
                        state_d  = (valid_q[idx][victim_d] && dirty_q[idx][victim_d]) ? WRITEBACK : FILL;
                    end
                end else if (flush) begin
                    state_d = FLUSH_SCAN;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[wb_way][wb_set], wb_set, 5'b0};
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[31:5], 5'b0};
                if (pmem_resp) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            FLUSH_SCAN: begin
                if (valid_q[sc_set][sc_way] && dirty_q[sc_set][sc_way]) begin
                    state_d = FLUSH_WB;
                end else if (cnt_q == '1) begin
                    flush_done = 1'b1;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH_WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[wb_way][wb_set], wb_set, 5'b0};
                if (pmem_resp) begin
                    clr_dirty = 1'b1;
                    if (cnt_q == '1) begin
                        flush_done = 1'b1;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = FLUSH_SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            victim_q <= '0;
            cnt_q    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            cnt_q    <= cnt_d;
            if (hit_we) dirty_q[idx][hit_way] <= 1'b1;
            if (fill_we) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
            if (clr_dirty) dirty_q[sc_set][sc_way] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (hit_we) data_q[hit_way][idx] <= merged_line;
        if (fill_we) begin
            data_q[victim_q][idx] <= pmem_rdata;
            tag_q[victim_q][idx]  <= tag;
        end
    end

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_plru
        plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
            .clk          (clk),
            .rst_n        (rst_n),
            .access_valid (plru_acc && (idx == IB'(s))),
            .access_way   (hit_way),
            .victim_way   (plru_vic[s])
        );
    end

endmodule

// File: tb/tb_param_l1_cache.sv
// Directed bench for param_l1_cache with a fixed-latency line memory model.
module tb_param_l1_cache;

    logic         clk;
    logic         rst_n;
    logic         mem_read, mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address, mem_wdata, mem_rdata;
    logic         mem_resp;
    logic         flush, flush_done;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    int nchk, nfail;
    logic [32:0]  plog[$];
    logic [255:0] mem [logic [31:0]];

    param_l1_cache #(.NUM_WAYS(4), .NUM_SETS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp), .flush(flush), .flush_done(flush_done),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] def_line(input logic [31:0] a);
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'h5A00_0000 | (a + 32'(4 * i));
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return def_line(a);
    endfunction

    // Lower memory: answers any request on its third cycle with a one-cycle pmem_resp.
    initial begin
        int lat;
        lat = 0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (pmem_read || pmem_write) begin
                nchk++;
                if (pmem_read && pmem_write) begin
                    nfail++;
                    $display("FAIL pmem_exclusive: read=%b write=%b required not both", pmem_read, pmem_write);
                end
            end
            if (pmem_resp) begin
                pmem_resp = 1'b0;
            end else if (rst_n && (pmem_read || pmem_write)) begin
                lat++;
                if (lat == 3) begin
                    lat = 0;
                    if (pmem_write) mem[pmem_address] = pmem_wdata;
                    else            pmem_rdata = mem_line(pmem_address);
                    plog.push_back({pmem_write, pmem_address});
                    pmem_resp = 1'b1;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // Issues one request aligned at posedge+1; cyc=-1 on timeout.
    task automatic access(input logic wr, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd, output int cyc);
        bit got;
        got = 0;
        rd  = 'x;
        cyc = 0;
        mem_read = !wr; mem_write = wr; mem_address = a; mem_byte_enable = be; mem_wdata = wd;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_resp) begin
                got = 1;
                rd  = mem_rdata;
            end
        end
        if (!got) cyc = -1;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic run_flush(output int ndone);
        ndone = 0;
        flush = 1'b1;
        for (int t = 0; t < 2000 && ndone == 0; t++) begin
            @(negedge clk);
            if (flush_done) ndone++;
        end
        @(posedge clk); #1 flush = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (flush_done) ndone++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nchk++; if (mem_resp !== 1'b0)   begin nfail++; $display("FAIL reset_mem_resp: got %b required 0", mem_resp); end
        nchk++; if (flush_done !== 1'b0) begin nfail++; $display("FAIL reset_flush_done: got %b required 0", flush_done); end
        nchk++; if (pmem_read !== 1'b0)  begin nfail++; $display("FAIL reset_pmem_read: got %b required 0", pmem_read); end
        nchk++; if (pmem_write !== 1'b0) begin nfail++; $display("FAIL reset_pmem_write: got %b required 0", pmem_write); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_cold_read();
        logic [31:0] rd; int cyc; logic [32:0] e0;
        plog.delete();
        access(1'b0, 32'h1004, 4'hF, 32'h0, rd, cyc);
        e0 = (plog.size() > 0) ? plog[0] : 33'h1_FFFF_FFFF;
        nchk++; if (rd !== 32'h5A00_1004) begin nfail++; $display("FAIL cold_rdata: got %h required 5a001004", rd); end
        nchk++; if (cyc < 2) begin nfail++; $display("FAIL cold_latency: got %0d required >1", cyc); end
        nchk++; if (plog.size() != 1) begin nfail++; $display("FAIL cold_traffic: got %0d pmem ops required 1", plog.size()); end
        nchk++; if (e0 !== {1'b0, 32'h1000}) begin nfail++; $display("FAIL cold_fill_addr: got %h required 0_00001000", e0); end
        access(1'b0, 32'h101C, 4'hF, 32'h0, rd, cyc);
        nchk++; if (rd !== 32'h5A00_101C) begin nfail++; $display("FAIL hit_rdata: got %h required 5a00101c", rd); end
        nchk++; if (cyc !== 1) begin nfail++; $display("FAIL hit_latency: got %0d required 1", cyc); end
        nchk++; if (plog.size() != 1) begin nfail++; $display("FAIL hit_traffic: got %0d pmem ops required 1", plog.size()); end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int cyc;
        plog.delete();
        access(1'b1, 32'h1008, 4'b0011, 32'hDEAD_BEEF, rd, cyc);
        nchk++; if (cyc !== 1) begin nfail++; $display("FAIL wr_hit_latency: got %0d required 1", cyc); end
        access(1'b0, 32'h1008, 4'hF, 32'h0, rd, cyc);
        nchk++; if (rd !== 32'h5A00_BEEF) begin nfail++; $display("FAIL wr_merge: got %h required 5a00beef", rd); end
        nchk++; if (cyc !== 1) begin nfail++; $display("FAIL wr_readback_latency: got %0d required 1", cyc); end
        nchk++; if (plog.size() != 0) begin nfail++; $display("FAIL wr_hit_traffic: got %0d pmem ops required 0", plog.size()); end
    endtask

    task automatic test_plru();
        logic [31:0] rd; int cyc; logic [32:0] e0, e1;
        access(1'b0, 32'h2000, 4'hF, 32'h0, rd, cyc);
        access(1'b1, 32'h3000, 4'hF, 32'h1111_2222, rd, cyc);
        access(1'b0, 32'h4000, 4'hF, 32'h0, rd, cyc);
        access(1'b0, 32'h1000, 4'hF, 32'h0, rd, cyc);
        nchk++; if (cyc !== 1) begin nfail++; $display("FAIL plru_touch_way0: got %0d cycles required 1", cyc); end
        plog.delete();
        access(1'b0, 32'h5000, 4'hF, 32'h0, rd, cyc);
        e0 = (plog.size() > 0) ? plog[0] : 33'h1_FFFF_FFFF;
        e1 = (plog.size() > 1) ? plog[1] : 33'h1_FFFF_FFFF;
        nchk++; if (plog.size() != 2) begin nfail++; $display("FAIL plru_traffic: got %0d pmem ops required 2", plog.size()); end
        nchk++; if (e0 !== {1'b1, 32'h3000}) begin nfail++; $display("FAIL plru_victim_wb: got %h required 1_00003000", e0); end
        nchk++; if (e1 !== {1'b0, 32'h5000}) begin nfail++; $display("FAIL plru_fill: got %h required 0_00005000", e1); end
        nchk++; if (rd !== 32'h5A00_5000) begin nfail++; $display("FAIL plru_rdata: got %h required 5a005000", rd); end
        access(1'b0, 32'h1004, 4'hF, 32'h0, rd, cyc);
        nchk++; if (cyc !== 1) begin nfail++; $display("FAIL plru_way0_kept: got %0d cycles required 1", cyc); end
        plog.delete();
        access(1'b0, 32'h3000, 4'hF, 32'h0, rd, cyc);
        e0 = (plog.size() > 0) ? plog[0] : 33'h1_FFFF_FFFF;
        nchk++; if (rd !== 32'h1111_2222) begin nfail++; $display("FAIL plru_wb_data: got %h required 11112222", rd); end
        nchk++; if (plog.size() != 1 || e0 !== {1'b0, 32'h3000}) begin nfail++; $display("FAIL plru_refill: got %0d ops first %h required 1 op 0_00003000", plog.size(), e0); end
    endtask

    task automatic test_flush();
        logic [31:0] rd, w; int cyc, nd; logic [32:0] e [3];
        logic [255:0] l;
        access(1'b1, 32'h1024, 4'hF, 32'hCAFE_F00D, rd, cyc);
        access(1'b1, 32'h1048, 4'hF, 32'h0123_4567, rd, cyc);
        plog.delete();
        run_flush(nd);
        for (int i = 0; i < 3; i++) e[i] = (plog.size() > i) ? plog[i] : 33'h1_FFFF_FFFF;
        nchk++; if (nd != 1) begin nfail++; $display("FAIL flush_done_pulses: got %0d required 1", nd); end
        nchk++; if (plog.size() != 3) begin nfail++; $display("FAIL flush_wb_count: got %0d required 3", plog.size()); end
        nchk++; if (e[0] !== {1'b1, 32'h1000}) begin nfail++; $display("FAIL flush_order0: got %h required 1_00001000", e[0]); end
        nchk++; if (e[1] !== {1'b1, 32'h1020}) begin nfail++; $display("FAIL flush_order1: got %h required 1_00001020", e[1]); end
        nchk++; if (e[2] !== {1'b1, 32'h1040}) begin nfail++; $display("FAIL flush_order2: got %h required 1_00001040", e[2]); end
        l = mem_line(32'h1020); w = l[63:32];
        nchk++; if (w !== 32'hCAFE_F00D) begin nfail++; $display("FAIL flush_data: got %h required cafef00d", w); end
        plog.delete();
        access(1'b0, 32'h1024, 4'hF, 32'h0, rd, cyc);
        nchk++; if (rd !== 32'hCAFE_F00D || cyc !== 1) begin nfail++; $display("FAIL post_flush_hit: got %h in %0d cycles required cafef00d in 1", rd, cyc); end
        access(1'b0, 32'h1048, 4'hF, 32'h0, rd, cyc);
        nchk++; if (rd !== 32'h0123_4567 || cyc !== 1) begin nfail++; $display("FAIL post_flush_hit2: got %h in %0d cycles required 01234567 in 1", rd, cyc); end
        run_flush(nd);
        nchk++; if (nd != 1) begin nfail++; $display("FAIL clean_flush_done: got %0d required 1", nd); end
        nchk++; if (plog.size() != 0) begin nfail++; $display("FAIL clean_flush_traffic: got %0d required 0", plog.size()); end
    endtask

    task automatic test_flush_priority();
        logic [31:0] rd, w; int cyc, stall, nd;
        logic [32:0] e0; logic [255:0] l;
        access(1'b1, 32'h1004, 4'hF, 32'h7777_7777, rd, cyc);
        plog.delete();
        mem_read = 1'b1; mem_address = 32'h1008; flush = 1'b1;
        @(negedge clk);
        nchk++; if (mem_resp !== 1'b1 || mem_rdata !== 32'h5A00_BEEF) begin nfail++; $display("FAIL prio_read_first: got resp %b data %h required 1 5a00beef", mem_resp, mem_rdata); end
        nchk++; if (flush_done !== 1'b0 || pmem_write !== 1'b0) begin nfail++; $display("FAIL prio_no_flush: got done %b wr %b required 0 0", flush_done, pmem_write); end
        @(posedge clk); #1 mem_read = 1'b0;
        stall = 0; nd = 0;
        for (int t = 0; t < 2000 && nd == 0; t++) begin
            @(negedge clk);
            if (mem_resp) stall++;
            if (flush_done) nd++;
            if (t == 1) begin mem_read = 1'b1; mem_address = 32'h1004; end
        end
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        nchk++; if (mem_resp !== 1'b1 || mem_rdata !== 32'h7777_7777) begin nfail++; $display("FAIL prio_after_flush: got resp %b data %h required 1 77777777", mem_resp, mem_rdata); end
        @(posedge clk); #1 mem_read = 1'b0;
        e0 = (plog.size() > 0) ? plog[0] : 33'h1_FFFF_FFFF;
        nchk++; if (nd != 1) begin nfail++; $display("FAIL prio_flush_done: got %0d required 1", nd); end
        nchk++; if (stall != 0) begin nfail++; $display("FAIL prio_stall: got %0d responses during flush required 0", stall); end
        nchk++; if (plog.size() != 1 || e0 !== {1'b1, 32'h1000}) begin nfail++; $display("FAIL prio_flush_wb: got %0d ops first %h required 1 op 1_00001000", plog.size(), e0); end
        l = mem_line(32'h1000); w = l[63:32];
        nchk++; if (w !== 32'h7777_7777) begin nfail++; $display("FAIL prio_wb_data: got %h required 77777777", w); end
    endtask

    task automatic test_reset_mid_wb();
        logic [31:0] rd; int cyc; bit seen; logic [32:0] e0;
        access(1'b1, 32'h10A0, 4'hF, 32'hAAAA_5555, rd, cyc);
        access(1'b0, 32'h20A0, 4'hF, 32'h0, rd, cyc);
        access(1'b0, 32'h30A0, 4'hF, 32'h0, rd, cyc);
        access(1'b0, 32'h40A0, 4'hF, 32'h0, rd, cyc);
        plog.delete();
        mem_read = 1'b1; mem_address = 32'h50A0;
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (pmem_write) seen = 1;
        end
        nchk++; if (!seen || pmem_address !== 32'h10A0) begin nfail++; $display("FAIL rst_wb_start: got seen %0d addr %h required 1 000010a0", seen, pmem_address); end
        #1 rst_n = 1'b0;
        #1;
        nchk++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin nfail++; $display("FAIL rst_async_drop: got wr %b rd %b required 0 0", pmem_write, pmem_read); end
        mem_read = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        nchk++; if (plog.size() != 0) begin nfail++; $display("FAIL rst_dropped_wb: got %0d completed ops required 0", plog.size()); end
        access(1'b0, 32'h20A0, 4'hF, 32'h0, rd, cyc);
        e0 = (plog.size() > 0) ? plog[0] : 33'h1_FFFF_FFFF;
        nchk++; if (cyc < 2 || rd !== 32'h5A00_20A0) begin nfail++; $display("FAIL rst_miss_after: got %0d cycles data %h required >1 5a0020a0", cyc, rd); end
        nchk++; if (plog.size() != 1 || e0 !== {1'b0, 32'h20A0}) begin nfail++; $display("FAIL rst_refill: got %0d ops first %h required 1 op 0_000020a0", plog.size(), e0); end
    endtask

    initial begin
        nchk = 0; nfail = 0;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 4'h0;
        mem_address = '0; mem_wdata = '0; flush = 1'b0;
        test_reset();
        test_cold_read();
        test_write_hit();
        test_plru();
        test_flush();
        test_flush_priority();
        test_reset_mid_wb();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/param_l1_cache.md
Name: param_l1_cache

Overview:
- Parametrised successor to the team's fixed-geometry L1: N-way set-associative, write-back, write-allocate L1 cache.
- Configurable ways and sets, tree pseudo-LRU replacement, and a new whole-cache flush (write back all dirty lines).
- Sits between a pipeline memory port (32-bit word, byte enables) and the 256-bit line-granular lower memory / arbiter.

Parameters:
- NUM_WAYS, 4, associativity; power of two, 2..8.
- NUM_SETS, 16, sets per way; power of two, 2..256.
- Line size is fixed at 256 bits (32 bytes); offset = addr[4:0], index = addr[5 +: log2(NUM_SETS)], tag = remaining upper bits.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  word read request; held until mem_resp.
- mem_write  in  1  word write request; held until mem_resp; never asserted together with mem_read.
- mem_byte_enable  in  4  write byte mask.
- mem_address  in  32  byte address; word select is addr[4:2].
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read data; valid when mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- flush  in  1  flush request; level, held until flush_done.
- flush_done  out  1  one-cycle pulse when the flush completes.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  32  line address, bits [4:0]=0.
- pmem_wdata  out  256  writeback line.
- pmem_rdata  in  256  fill line.
- pmem_resp  in  1  lower-memory completion pulse.

Behaviour:
- Reset (rst_n=0, async): FSM to IDLE. All valid, dirty and PLRU bits cleared; flush counter cleared. mem_resp, flush_done, pmem_read and pmem_write deassert immediately. Data/tag arrays are not cleared.
- Reset mid-transaction abandons it; lower memory must tolerate a dropped request.
- States: IDLE, WRITEBACK, FILL, FLUSH_SCAN, FLUSH_WB.
- IDLE, request present: combinational tag compare across all ways.
- Hit: mem_resp=1 in the same cycle, and mem_rdata = the selected word.
  - Write hit: merge the 32-bit word into the line by byte mask at the clock edge; set dirty.
  - PLRU updated to mark the hit way most-recent.
  - Hit latency: 1 cycle from request.
- Miss: victim = first invalid way (lowest index); otherwise the PLRU victim.
  - Victim valid and dirty -> WRITEBACK; else -> FILL.
- WRITEBACK: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata = victim line, all held stable.
  - On pmem_resp -> FILL.
- FILL: pmem_read=1, pmem_address = request line address.
  - On pmem_resp: write line, tag, valid=1, dirty=0 -> IDLE. The request then hits on the next cycle.
  - Miss latency = 1 + fill (+ writeback) cycles.
- Priority in IDLE: a mem request beats flush. Flush is taken only when mem_read=mem_write=0.
- FLUSH_SCAN: counter walks {set, way} from 0 to NUM_SETS*NUM_WAYS-1, one entry per cycle.
  - Valid and dirty entry -> FLUSH_WB.
  - FLUSH_WB: pmem_write with that line; on pmem_resp clear dirty, resume scan at the next entry.
  - After the last entry: flush_done=1 for one cycle, counter resets -> IDLE.
  - Valid bits are kept, so contents remain readable after a flush.
- mem requests arriving during a flush are stalled (no mem_resp) until after flush_done.
- pmem_read and pmem_write are never both 1. Each holds until pmem_resp.
- PLRU: NUM_WAYS-1 tree bits per set. On access, update each node on the path to point away from the accessed way. Victim = follow the bits from the root.
- The PLRU is updated on hits only; a fill is followed by a hit, which updates it.

Decomposition:
- Package l1_cache_pkg: state enum l1_state_t, OFFSET_BITS=5, LINE_BITS=256, and functions for index/tag widths from NUM_SETS.
- Sub-module plru_tree (parameter NUM_WAYS): holds one set's tree.
  - Inputs: access_valid, access_way. Output: victim_way.
  - Instantiated per set, or as a single array with a shared combinational update function.
- Datapath and control stay in this module; byte-enable expansion to 256 bits is inline.

Test Plan:
- Cold read 0x0000_1004, NUM_WAYS=4 -> one pmem_read at 0x0000_1000. After pmem_resp, mem_rdata = word 1 of the fill line with mem_resp=1, and no pmem_write.
- Write 0xDEADBEEF, mask 4'b0011, to a hit 0x1008 -> mem_resp in 1 cycle. A readback returns the upper 16 bits unchanged and the lower 16 bits = 0xBEEF.
- Fill 5 distinct tags to set 0 with 4 ways, touching way 0 again before the 5th -> the evicted way is the PLRU victim, not way 0. If the victim is dirty, pmem_write to its old address precedes pmem_read.
- Dirty 3 lines in different sets, then assert flush -> exactly 3 pmem_write in ascending {set, way} order, then one flush_done pulse. Re-reading those lines hits with no pmem traffic.
- Assert rst_n=0 while in WRITEBACK -> pmem_write drops in the same cycle. After release, a read to a previously filled address misses.
- Simultaneous flush and mem_read in IDLE -> the read is serviced first; the flush starts on the cycle after mem_resp.
